exe_div_unit: RTL and testbench

//  Iterative radix-2 restoring divider used by the EXE stage for div.w/mod.w/div.wu/mod.wu.
//  EXE hands over operands with a valid/ready handshake and stalls (exe_allowin low) until
//  res_valid; quotient and remainder go onward into the EXE result bus toward MEM.
//  One divide in flight; no internal queue.

---
 rtl/exe_div_unit_pkg.sv | 23 ++
 rtl/exe_div_unit_div_step.sv | 31 +++
 rtl/exe_div_unit.sv | 185 ++++++++++++++++++
 tb/tb_exe_div_unit.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_div_unit_pkg.sv
// ----------------------------------------------------------------------------
// exe_div_unit_pkg
//   Shared definitions for the EXE-stage iterative divider:
//   - div_state_e : FSM state encodings (DIV_IDLE / DIV_CALC / DIV_DONE, 2 bits)
//   - DIV_WIDTH_DEF : default operand width
//   - div_cnt_w() : iteration counter width for a given operand width
// ----------------------------------------------------------------------------
package exe_div_unit_pkg;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_CALC = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   localparam int DIV_WIDTH_DEF = 32;

   // Counter must hold WIDTH-1; never narrower than one bit.
   function automatic int div_cnt_w(input int width);
      return (width > 2) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/exe_div_unit_div_step.sv
// ----------------------------------------------------------------------------
// exe_div_unit_div_step
//   One combinational iteration of a radix-2 restoring divider.
//   Ports:
//     rem_in   in  WIDTH  partial remainder from the previous iteration
//     dvd_bit  in  1      next dividend bit (MSB first)
//     divisor  in  WIDTH  divisor magnitude
//     rem_out  out WIDTH  partial remainder after this iteration
//     q_bit    out 1      quotient bit produced by this iteration
// ----------------------------------------------------------------------------
module exe_div_unit_div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic             dvd_bit,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic             q_bit
);

   logic [WIDTH:0] partial;

   always_comb begin
      partial = {rem_in, dvd_bit};
      q_bit   = (partial >= {1'b0, divisor});
      // When the subtraction succeeds the true difference is below the
      // divisor, so modular WIDTH-bit arithmetic on the low bits is exact.
      rem_out = q_bit ? (partial[WIDTH-1:0] - divisor) : partial[WIDTH-1:0];
   end

endmodule

// File: rtl/exe_div_unit.sv
// ----------------------------------------------------------------------------
// exe_div_unit
//   Iterative radix-2 restoring divider for div.w / mod.w / div.wu / mod.wu.
//   One divide in flight; WIDTH iterations per divide, one quotient bit per
//   cycle, followed by sign correction into registered outputs.
//
//   Optional feature macro: DIV_EARLY_OUT_EN
//     When defined, a divide whose dividend magnitude is below the divisor
//     magnitude skips iteration and completes the cycle after accept with
//     q=0, r=dividend.
//
//   Ports:
//     clk         in   1      core clock
//     resetn      in   1      asynchronous active-low reset
//     div_valid   in   1      divide request
//     div_ready   out  1      unit idle, can accept
//     div_signed  in   1      1 = signed, 0 = unsigned
//     div_src1    in   WIDTH  dividend
//     div_src2    in   WIDTH  divisor
//     div_flush   in   1      cancel any operation, return to idle
//     res_valid   out  1      result valid, held until res_ready
//     res_ready   in   1      result consumed this cycle
//     quotient    out  WIDTH  quotient
//     remainder   out  WIDTH  remainder (sign of dividend when signed)
// ----------------------------------------------------------------------------
module exe_div_unit
   import exe_div_unit_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEF
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             div_valid,
   output logic             div_ready,
   input  logic             div_signed,
   input  logic [WIDTH-1:0] div_src1,
   input  logic [WIDTH-1:0] div_src2,
   input  logic             div_flush,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int CNT_W = div_cnt_w(WIDTH);

   // Magnitude of an operand, taken only for signed operations.
   function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v,
                                                input logic             is_signed);
      return (is_signed && v[WIDTH-1]) ? (~v + 1'b1) : v;
   endfunction

   // Two's-complement negate on request; wraps for the most negative value.
   function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v,
                                               input logic             neg);
      return neg ? (~v + 1'b1) : v;
   endfunction

   div_state_e       state_q,     state_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;
   logic             q_sign_q,    q_sign_d;
   logic             r_sign_q,    r_sign_d;
   logic [WIDTH-1:0] quotient_q,  quotient_d;
   logic [WIDTH-1:0] remainder_q, remainder_d;
   logic [WIDTH-1:0] rem_q,       rem_d;
   logic [WIDTH-1:0] dvd_q,       dvd_d;
   logic [WIDTH-1:0] dvs_q,       dvs_d;

   logic [WIDTH-1:0] src1_abs;
   logic [WIDTH-1:0] src2_abs;
   logic             src1_neg;
   logic             src2_neg;
   logic [WIDTH-1:0] step_rem;
   logic             step_q_bit;
   logic [WIDTH-1:0] quo_next;

   assign src1_neg = div_signed & div_src1[WIDTH-1];
   assign src2_neg = div_signed & div_src2[WIDTH-1];
   assign src1_abs = abs_val(div_src1, div_signed);
   assign src2_abs = abs_val(div_src2, div_signed);

   // Dividend register doubles as the quotient shift register: dividend bits
   // leave at the top while quotient bits enter at the bottom.
   exe_div_unit_div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .rem_in  (rem_q),
      .dvd_bit (dvd_q[WIDTH-1]),
      .divisor (dvs_q),
      .rem_out (step_rem),
      .q_bit   (step_q_bit)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      q_sign_d    = q_sign_q;
      r_sign_d    = r_sign_q;
      quotient_d  = quotient_q;
      remainder_d = remainder_q;
      rem_d       = rem_q;
      dvd_d       = dvd_q;
      dvs_d       = dvs_q;
      quo_next    = {dvd_q[WIDTH-2:0], step_q_bit};

      case (state_q)
         DIV_IDLE: begin
            if (div_valid && !div_flush) begin
               rem_d    = '0;
               dvd_d    = src1_abs;
               dvs_d    = src2_abs;
               q_sign_d = src1_neg ^ src2_neg;
               r_sign_d = src1_neg;
               cnt_d    = CNT_W'(WIDTH - 1);
               state_d  = DIV_CALC;
`ifdef DIV_EARLY_OUT_EN
               // |src1| < |src2| already implies a non-zero divisor.
               if (src1_abs < src2_abs) begin
                  cnt_d       = '0;
                  quotient_d  = '0;
                  remainder_d = div_src1;
                  state_d     = DIV_DONE;
               end
`endif
            end
         end
         DIV_CALC: begin
            rem_d = step_rem;
            dvd_d = quo_next;
            if (cnt_q == '0) begin
               quotient_d  = neg_if(quo_next, q_sign_q);
               remainder_d = neg_if(step_rem, r_sign_q);
               state_d     = DIV_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DIV_DONE: begin
            if (res_ready) begin
               state_d = DIV_IDLE;
            end
         end
         default: begin
            state_d = DIV_IDLE;
         end
      endcase

      // Flush overrides accept and result hand-off alike.
      if (div_flush) begin
         state_d = DIV_IDLE;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q     <= DIV_IDLE;
         cnt_q       <= '0;
         q_sign_q    <= 1'b0;
         r_sign_q    <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         q_sign_q    <= q_sign_d;
         r_sign_q    <= r_sign_d;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
      end
   end

   // Working datapath registers are always loaded at accept before use.
   always_ff @(posedge clk) begin
      rem_q <= rem_d;
      dvd_q <= dvd_d;
      dvs_q <= dvs_d;
   end

   assign div_ready = (state_q == DIV_IDLE);
   assign res_valid = (state_q == DIV_DONE);
   assign quotient  = quotient_q;
   assign remainder = remainder_q;

endmodule

// File: tb/tb_exe_div_unit.sv
module tb_exe_div_unit;

   logic        clk;
   logic        resetn;
   logic        div_valid;
   logic        div_ready;
   logic        div_signed;
   logic [31:0] div_src1;
   logic [31:0] div_src2;
   logic        div_flush;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] quotient;
   logic [31:0] remainder;

   int tests;
   int fails;

   exe_div_unit #(.WIDTH(32)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .div_valid  (div_valid),
      .div_ready  (div_ready),
      .div_signed (div_signed),
      .div_src1   (div_src1),
      .div_src2   (div_src2),
      .div_flush  (div_flush),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .quotient   (quotient),
      .remainder  (remainder)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one request; returns 1 ns after the accept edge.
   task automatic start_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      int n;
      n = 0;
      while (!div_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!div_ready) begin
         tests++; fails++;
         $display("FAIL start_ready got=%0b want=1", div_ready);
      end
      div_signed = sgn;
      div_src1   = a;
      div_src2   = b;
      div_valid  = 1'b1;
      @(posedge clk); #1;
      div_valid  = 1'b0;
   endtask

   // Cycles from accept edge until res_valid seen (bounded at 100).
   task automatic wait_res(output int cyc);
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
      end while (!res_valid && cyc < 100);
   endtask

   task automatic test_reset();
      tests++; if (div_ready !== 1'b1) begin fails++; $display("FAIL rst_div_ready got=%0b want=1", div_ready); end
      tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL rst_res_valid got=%0b want=0", res_valid); end
      tests++; if (quotient !== 32'h0) begin fails++; $display("FAIL rst_quotient got=%h want=0", quotient); end
      tests++; if (remainder !== 32'h0) begin fails++; $display("FAIL rst_remainder got=%h want=0", remainder); end
   endtask

   task automatic test_unsigned();
      int c;
      res_ready = 1'b1;
      start_div(1'b0, 32'd100, 32'd7);
      wait_res(c);
      tests++; if (c != 32) begin fails++; $display("FAIL u_latency got=%0d want=32", c); end
      tests++; if (quotient !== 32'd14) begin fails++; $display("FAIL u_quot got=%h want=%h", quotient, 32'd14); end
      tests++; if (remainder !== 32'd2) begin fails++; $display("FAIL u_rem got=%h want=%h", remainder, 32'd2); end
      @(posedge clk); #1;
      tests++; if (div_ready !== 1'b1) begin fails++; $display("FAIL u_ready_after got=%0b want=1", div_ready); end
      tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL u_valid_after got=%0b want=0", res_valid); end
   endtask

   task automatic test_signed();
      int c;
      res_ready = 1'b1;
      start_div(1'b1, 32'hFFFF_FFF9, 32'd2);   // -7 / 2
      wait_res(c);
      tests++; if (quotient !== 32'hFFFF_FFFD) begin fails++; $display("FAIL s_n7_2_quot got=%h want=FFFFFFFD", quotient); end
      tests++; if (remainder !== 32'hFFFF_FFFF) begin fails++; $display("FAIL s_n7_2_rem got=%h want=FFFFFFFF", remainder); end
      @(posedge clk); #1;
      start_div(1'b1, 32'd7, 32'hFFFF_FFFE);   // 7 / -2
      wait_res(c);
      tests++; if (quotient !== 32'hFFFF_FFFD) begin fails++; $display("FAIL s_7_n2_quot got=%h want=FFFFFFFD", quotient); end
      tests++; if (remainder !== 32'd1) begin fails++; $display("FAIL s_7_n2_rem got=%h want=00000001", remainder); end
      @(posedge clk); #1;
   endtask

   task automatic test_boundary();
      int c;
      res_ready = 1'b1;
      start_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_res(c);
      tests++; if (quotient !== 32'h8000_0000) begin fails++; $display("FAIL ovf_quot got=%h want=80000000", quotient); end
      tests++; if (remainder !== 32'h0) begin fails++; $display("FAIL ovf_rem got=%h want=0", remainder); end
      @(posedge clk); #1;
      start_div(1'b0, 32'd5, 32'd0);
      wait_res(c);
      tests++; if (quotient !== 32'hFFFF_FFFF) begin fails++; $display("FAIL dz_u_quot got=%h want=FFFFFFFF", quotient); end
      tests++; if (remainder !== 32'd5) begin fails++; $display("FAIL dz_u_rem got=%h want=5", remainder); end
      @(posedge clk); #1;
      start_div(1'b1, 32'd7, 32'd0);
      wait_res(c);
      tests++; if (quotient !== 32'hFFFF_FFFF) begin fails++; $display("FAIL dz_s_quot got=%h want=FFFFFFFF", quotient); end
      tests++; if (remainder !== 32'd7) begin fails++; $display("FAIL dz_s_rem got=%h want=7", remainder); end
      @(posedge clk); #1;
   endtask

   task automatic test_flush();
      int c;
      int seen;
      res_ready = 1'b1;
      start_div(1'b0, 32'd1000, 32'd3);
      repeat (10) begin @(posedge clk); #1; end
      div_flush = 1'b1;
      @(posedge clk); #1;
      div_flush = 1'b0;
      tests++; if (div_ready !== 1'b1) begin fails++; $display("FAIL flush_ready got=%0b want=1", div_ready); end
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (res_valid) seen++;
         @(posedge clk); #1;
      end
      tests++; if (seen != 0) begin fails++; $display("FAIL flush_no_result got=%0d want=0", seen); end
      // Flush beats a simultaneous accept.
      div_valid = 1'b1; div_flush = 1'b1; div_signed = 1'b0;
      div_src1 = 32'd20; div_src2 = 32'd4;
      @(posedge clk); #1;
      div_valid = 1'b0; div_flush = 1'b0;
      tests++; if (div_ready !== 1'b1) begin fails++; $display("FAIL flush_vs_accept got=%0b want=1", div_ready); end
      start_div(1'b0, 32'd9, 32'd3);
      wait_res(c);
      tests++; if (c != 32) begin fails++; $display("FAIL flush_next_lat got=%0d want=32", c); end
      tests++; if (quotient !== 32'd3) begin fails++; $display("FAIL flush_next_quot got=%h want=3", quotient); end
      tests++; if (remainder !== 32'd0) begin fails++; $display("FAIL flush_next_rem got=%h want=0", remainder); end
      @(posedge clk); #1;
   endtask

   task automatic test_hold();
      int c;
      res_ready = 1'b0;
      start_div(1'b0, 32'd50, 32'd6);
      wait_res(c);
      tests++; if (c != 32) begin fails++; $display("FAIL hold_lat got=%0d want=32", c); end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         tests++; if (res_valid !== 1'b1) begin fails++; $display("FAIL hold_valid[%0d] got=%0b want=1", i, res_valid); end
         tests++; if (div_ready !== 1'b0) begin fails++; $display("FAIL hold_ready[%0d] got=%0b want=0", i, div_ready); end
         tests++; if (quotient !== 32'd8) begin fails++; $display("FAIL hold_quot[%0d] got=%h want=8", i, quotient); end
         tests++; if (remainder !== 32'd2) begin fails++; $display("FAIL hold_rem[%0d] got=%h want=2", i, remainder); end
      end
      res_ready = 1'b1;
      @(posedge clk); #1;
      tests++; if (div_ready !== 1'b1) begin fails++; $display("FAIL hold_release got=%0b want=1", div_ready); end
   endtask

   task automatic test_early_out();
      int c;
      res_ready = 1'b1;
      start_div(1'b0, 32'd3, 32'd10);
      wait_res(c);
`ifdef DIV_EARLY_OUT_EN
      tests++; if (c != 1) begin fails++; $display("FAIL early_lat got=%0d want=1", c); end
`else
      tests++; if (c != 32) begin fails++; $display("FAIL early_lat got=%0d want=32", c); end
`endif
      tests++; if (quotient !== 32'd0) begin fails++; $display("FAIL early_quot got=%h want=0", quotient); end
      tests++; if (remainder !== 32'd3) begin fails++; $display("FAIL early_rem got=%h want=3", remainder); end
      @(posedge clk); #1;
      start_div(1'b1, 32'hFFFF_FFFD, 32'd10);  // -3 / 10
      wait_res(c);
      tests++; if (quotient !== 32'd0) begin fails++; $display("FAIL early_s_quot got=%h want=0", quotient); end
      tests++; if (remainder !== 32'hFFFF_FFFD) begin fails++; $display("FAIL early_s_rem got=%h want=FFFFFFFD", remainder); end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      int c;
      res_ready = 1'b1;
      start_div(1'b0, 32'hFFFF_FFFF, 32'h10);
      // Request held and operands changed while busy: must be ignored.
      div_valid = 1'b1;
      div_src1  = 32'h1234_5678;
      div_src2  = 32'd1;
      wait_res(c);
      tests++; if (quotient !== 32'h0FFF_FFFF) begin fails++; $display("FAIL b2b_quot got=%h want=0FFFFFFF", quotient); end
      tests++; if (remainder !== 32'hF) begin fails++; $display("FAIL b2b_rem got=%h want=F", remainder); end
      @(posedge clk); #1;
      tests++; if (div_ready !== 1'b1) begin fails++; $display("FAIL b2b_idle got=%0b want=1", div_ready); end
      @(posedge clk); #1;
      div_valid = 1'b0;
      tests++; if (div_ready !== 1'b0) begin fails++; $display("FAIL b2b_accept got=%0b want=0", div_ready); end
      wait_res(c);
      tests++; if (c != 32) begin fails++; $display("FAIL b2b_lat got=%0d want=32", c); end
      tests++; if (quotient !== 32'h1234_5678) begin fails++; $display("FAIL b2b2_quot got=%h want=12345678", quotient); end
      tests++; if (remainder !== 32'd0) begin fails++; $display("FAIL b2b2_rem got=%h want=0", remainder); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      res_ready = 1'b1;
      start_div(1'b0, 32'd100, 32'd7);
      repeat (5) begin @(posedge clk); #1; end
      resetn = 1'b0;
      #1;
      tests++; if (div_ready !== 1'b1) begin fails++; $display("FAIL rmid_ready got=%0b want=1", div_ready); end
      tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL rmid_valid got=%0b want=0", res_valid); end
      tests++; if (quotient !== 32'h0) begin fails++; $display("FAIL rmid_quot got=%h want=0", quotient); end
      tests++; if (remainder !== 32'h0) begin fails++; $display("FAIL rmid_rem got=%h want=0", remainder); end
      @(posedge clk); #1;
      resetn = 1'b1;
      @(posedge clk); #1;
      tests++; if (div_ready !== 1'b1) begin fails++; $display("FAIL rmid_after got=%0b want=1", div_ready); end
   endtask

   initial begin
      tests      = 0;
      fails      = 0;
      resetn     = 1'b0;
      div_valid  = 1'b0;
      div_signed = 1'b0;
      div_src1   = '0;
      div_src2   = '0;
      div_flush  = 1'b0;
      res_ready  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      resetn = 1'b1;
      @(posedge clk); #1;
      test_reset();
      test_unsigned();
      test_signed();
      test_boundary();
      test_flush();
      test_hold();
      test_early_out();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
